// File: rtl/cs_measure.sv
// Compressive-sensing measurement stage: buffers one frame of N samples, then
// streams M signed 16-bit projections onto a +/-1 LFSR-generated matrix, MSB first.
module cs_measure #(
  parameter int          N    = 64,
  parameter int          M    = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int          KW     = $clog2(N);
  localparam int          MW     = (M > 1) ? $clog2(M) : 1;
  localparam logic [15:0] MASK   = 16'hB400;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [MW-1:0] M_LAST = MW'(M - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_EMIT_HI, ST_EMIT_LO} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [MW-1:0] m_q, m_d;
  logic [15:0]   acc_q, acc_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [7:0]    smp_mem [N];
  logic          smp_we;
  logic [15:0]   smp_ext;
  logic [15:0]   acc_sum;
  logic [15:0]   lfsr_next;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    m_d          = m_q;
    acc_d        = acc_q;
    lfsr_d       = lfsr_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    smp_we       = 1'b0;

    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? MASK : 16'h0000);
    smp_ext   = {8'h00, smp_mem[k_q]};
    acc_sum   = lfsr_q[0] ? (acc_q + smp_ext) : (acc_q - smp_ext);

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          smp_we = 1'b1;
          if (k_q == K_LAST) begin
            k_d     = '0;
            m_d     = '0;
            acc_d   = '0;
            lfsr_d  = SEED;
            state_d = ST_COMPUTE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        acc_d  = acc_sum;
        lfsr_d = lfsr_next;
        if (k_q == K_LAST) begin
          k_d        = '0;
          out_data_d = acc_sum[15:8];
          state_d    = ST_EMIT_HI;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_EMIT_HI: begin
        if (out_ready) begin
          out_data_d = acc_q[7:0];
          state_d    = ST_EMIT_LO;
        end
      end
      ST_EMIT_LO: begin
        if (out_ready) begin
          out_data_d = 8'h00;
          if (m_q == M_LAST) begin
            m_d          = '0;
            lfsr_d       = SEED;
            frame_done_d = 1'b1;
            state_d      = ST_LOAD;
          end else begin
            // LFSR keeps running so the next row draws fresh matrix bits
            m_d     = m_q + 1'b1;
            acc_d   = '0;
            state_d = ST_COMPUTE;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    out_valid_d = (state_d == ST_EMIT_HI) || (state_d == ST_EMIT_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      k_q          <= '0;
      m_q          <= '0;
      acc_q        <= '0;
      lfsr_q       <= SEED;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      m_q          <= m_d;
      acc_q        <= acc_d;
      lfsr_q       <= lfsr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Sample buffer needs no reset: every entry is rewritten before COMPUTE reads it
  always_ff @(posedge clk) begin
    if (smp_we) smp_mem[k_q] <= in_data;
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_LOAD);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cs_measure.sv
// Directed bench for cs_measure: table of frame scenarios checked against a
// behavioural projection model, plus a small-N instance with hand-computed results.
module tb_cs_measure;

  localparam int          N    = 64;
  localparam int          M    = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, busy, frame_done;
  logic [7:0] out_data;
  logic       x_in_ready, x_out_valid, x_busy, x_frame_done;
  logic [7:0] x_out_data;

  always #5 clk = ~clk;

  cs_measure #(.N(N), .M(M), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  // Seed 0x00FF: the first 8 matrix bits are the seed's low byte, so row 0 is all +1
  cs_measure #(.N(8), .M(2), .SEED(16'h00FF)) u_ext (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(x_in_ready), .out_valid(x_out_valid), .out_data(x_out_data),
    .out_ready(out_ready), .busy(x_busy), .frame_done(x_frame_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]  frame [N];
  logic [15:0] exp_y [M];
  logic [7:0]  got [$];
  logic [7:0]  x_got [$];
  int          first_cyc, last_acc, fd_cnt, fd_cyc;
  bit          first_seen;
  bit          prev_stall;
  logic [7:0]  prev_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_while_stalled", {23'h0, out_valid, out_data}, {23'h0, 1'b1, prev_data});
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (x_out_valid && out_ready) x_got.push_back(x_out_data);
      if (in_valid && in_ready) last_acc = cyc;
      if (in_valid && busy) chk("ignored_in_ready", in_ready, 0);
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
        chk("fd_in_ready", in_ready, 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_frame(input int pat);
    for (int n = 0; n < N; n++)
      frame[n] = (pat == 1) ? 8'h01 : (pat == 2) ? 8'hFF : (pat == 3) ? 8'(n) : 8'h00;
  endtask

  // y_m = sum_n phi(m,n)*x[n], phi from Galois LFSR bit 0, one advance per term
  task automatic model_frame();
    logic [15:0] l;
    logic [15:0] acc;
    l = SEED;
    for (int m = 0; m < M; m++) begin
      acc = 16'h0;
      for (int n = 0; n < N; n++) begin
        if (l[0]) acc = acc + {8'h00, frame[n]};
        else      acc = acc - {8'h00, frame[n]};
        l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      end
      exp_y[m] = acc;
    end
  endtask

  task automatic chk_rst(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 1);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_data"}, out_data, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_frame_done"}, frame_done, 0);
  endtask

  task automatic load_frame();
    for (int n = 0; n < N; n++) begin
      in_valid = 1'b1;
      in_data  = frame[n];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic run_frame(input bit bp, input bit junk);
    int c;
    c = 0;
    while (fd_cnt == 0 && c < 20000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = junk && busy && ($urandom_range(0, 3) == 0);
      in_data   = 8'($urandom);
      tick();
      c++;
    end
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic pre_rst_compute();
    load_frame();
    out_ready = 1'b1;
    repeat (5 * (N + 2) + 3) tick();
    chk("row5_compute", {busy, out_valid}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk_rst("rst_compute");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pre_rst_emit();
    load_frame();
    out_ready = 1'b0;
    for (int c = 0; c < 200 && !out_valid; c++) tick();
    chk("emit_hi_reached", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("emit_lo_held", {busy, out_valid}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk_rst("rst_emit");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    int pat;   // 0 zero, 1 all 0x01, 2 all 0xFF, 3 ramp
    bit bp;    // random out_ready back-pressure
    bit junk;  // in_valid pulses while busy
    int pre;   // 1 reset in COMPUTE row 5 first, 2 reset in EMIT_LO first
    int rel;   // 1 save as reference, 2 expect 255x reference, 3 expect reference
    bit tim;   // expect exact latency and frame length
  } vec_t;

  initial begin
    vec_t        tbl [9];
    logic [15:0] y_ref [M];
    logic [15:0] cap [M];
    logic [7:0]  x_exp [4];

    tbl[0] = '{0, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[1] = '{1, 1'b0, 1'b0, 0, 1, 1'b1};
    tbl[2] = '{2, 1'b0, 1'b0, 0, 2, 1'b1};
    tbl[3] = '{1, 1'b0, 1'b0, 0, 3, 1'b1};
    tbl[4] = '{3, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[5] = '{3, 1'b0, 1'b1, 0, 0, 1'b1};
    tbl[6] = '{3, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[7] = '{1, 1'b0, 1'b0, 1, 3, 1'b1};
    tbl[8] = '{0, 1'b0, 1'b0, 2, 0, 1'b1};
    x_exp = '{8'h07, 8'hF8, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk_rst("reset");
    chk("reset_x_in_ready", x_in_ready, 1);
    chk("reset_x_out_valid", x_out_valid, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      fill_frame(tbl[i].pat);
      model_frame();
      if (tbl[i].pre == 1) pre_rst_compute();
      else if (tbl[i].pre == 2) pre_rst_emit();
      got.delete();
      fd_cnt     = 0;
      first_seen = 1'b0;
      load_frame();
      run_frame(tbl[i].bp, tbl[i].junk);

      chk("frame_done_pulses", fd_cnt, 1);
      chk("transfer_count", got.size(), 2 * M);
      if (got.size() == 2 * M) begin
        for (int m = 0; m < M; m++) begin
          cap[m] = {got[2*m], got[2*m+1]};
          chk($sformatf("v%0d_y%0d", i, m), cap[m], exp_y[m]);
          if (tbl[i].rel == 1) y_ref[m] = cap[m];
          if (tbl[i].rel == 2) chk($sformatf("v%0d_ff_255x_y%0d", i, m), cap[m], 16'(y_ref[m] * 16'd255));
          if (tbl[i].rel == 3) chk($sformatf("v%0d_repeat_y%0d", i, m), cap[m], y_ref[m]);
        end
      end
      if (tbl[i].tim) begin
        chk("first_valid_latency", first_cyc - last_acc, N + 1);
        chk("frame_done_cycle", fd_cyc - last_acc, M * (N + 2) + 1);
      end
      chk("back_in_load", in_ready, 1);
    end

    // Extreme magnitude on the small instance: row 0 = 8*255 = 0x07F8, row 1 balanced
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    x_got.delete();
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && x_got.size() < 4; c++) tick();
    chk("ext_transfer_count", x_got.size(), 4);
    if (x_got.size() == 4)
      for (int b = 0; b < 4; b++) chk($sformatf("ext_byte%0d", b), x_got[b], x_exp[b]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
